// File: rtl/kgp_risc_pkg.sv
// Shared register-file constants and writeback requester IDs for the kgp RISC core.
// Contents: register address/data widths, register count, writeback source indices,
//           and a small index-wrap helper used by round-robin pointers.
package kgp_risc_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned NUM_REGS   = 32;

  // Writeback requester indices on the register-file write arbiter
  localparam int unsigned REQ_ALU  = 0;
  localparam int unsigned REQ_MEM  = 1;
  localparam int unsigned REQ_LINK = 2;

  // Increment an index modulo n
  function automatic int unsigned wrapInc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req     in  NUM_REQ  request vector
//   ptr     in  IDX_W    highest-priority index this cycle
//   en      in  1        0: no grant issued
//   gnt     out NUM_REQ  one-hot grant (all zero when nothing granted)
//   gnt_idx out IDX_W    index of the granted requester (0 when none)
//   any_gnt out 1        a grant was issued
module rr_arbiter
  import kgp_risc_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any_gnt
);

  localparam int N = int'(NUM_REQ);

  logic [2*NUM_REQ-1:0] reqDbl;

  // Search the doubled vector from ptr upward so the wrap-around needs no modulo
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    reqDbl  = {req, req};
    if (en) begin
      for (int i = 0; i < 2 * N; i++) begin
        if (!any_gnt && (i >= int'(ptr)) && (i < int'(ptr) + N) && reqDbl[i]) begin
          any_gnt = 1'b1;
          gnt_idx = (i >= N) ? IDX_W'(i - N) : IDX_W'(i);
        end
      end
    end
    if (any_gnt) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between NUM_REQ writeback sources with
// round-robin arbitration and a registered output stage; flags pending writes
// to the decode read addresses for stall logic.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   stall                      1: no new grants this cycle
//   req_valid/req_ready        per-requester handshake (req_ready one-hot, combinational)
//   req_addr/req_data          packed per-requester target register and data
//   Write/WriteRegister/WriteData  registered register-file write port
//   rd_addr1/rd_addr2          decode read addresses
//   rd_pending1/rd_pending2    write to that address requested or in flight (combinational)
module regfile_write_arbiter
  import kgp_risc_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = REG_ADDR_W,
  parameter int unsigned DATA_W  = REG_DATA_W,
  parameter bit          DROP_R0 = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      Write,
  output logic [ADDR_W-1:0]         WriteRegister,
  output logic [DATA_W-1:0]         WriteData,
  input  logic [ADDR_W-1:0]         rd_addr1,
  input  logic [ADDR_W-1:0]         rd_addr2,
  output logic                      rd_pending1,
  output logic                      rd_pending2
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  ptrNext;
  logic [IDX_W-1:0]  gntIdx;
  logic              anyGnt;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selData;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) uArb (
    .req     (req_valid),
    .ptr     (ptr),
    .en      (!rst && !stall),
    .gnt     (req_ready),
    .gnt_idx (gntIdx),
    .any_gnt (anyGnt)
  );

  // Winner's address/data and the pointer position just past it
  always_comb begin
    selAddr = '0;
    selData = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gntIdx == IDX_W'(i)) begin
        selAddr = req_addr[i*ADDR_W +: ADDR_W];
        selData = req_data[i*DATA_W +: DATA_W];
      end
    end
    ptrNext = IDX_W'(wrapInc(32'(gntIdx), NUM_REQ));
  end

  // Pointer and output stage; a register-0 write is consumed but not issued
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr           <= '0;
      Write         <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else if (anyGnt) begin
      ptr           <= ptrNext;
      Write         <= !(DROP_R0 && (selAddr == '0));
      WriteRegister <= selAddr;
      WriteData     <= selData;
    end else begin
      Write <= 1'b0;
    end
  end

  // Hazard flags: in-flight write or any outstanding request to the read address
  always_comb begin
    rd_pending1 = Write && (WriteRegister == rd_addr1);
    rd_pending2 = Write && (WriteRegister == rd_addr2);
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (req_valid[i] && (req_addr[i*ADDR_W +: ADDR_W] == rd_addr1)) rd_pending1 = 1'b1;
      if (req_valid[i] && (req_addr[i*ADDR_W +: ADDR_W] == rd_addr2)) rd_pending2 = 1'b1;
    end
    if (DROP_R0 && (rd_addr1 == '0)) rd_pending1 = 1'b0;
    if (DROP_R0 && (rd_addr2 == '0)) rd_pending2 = 1'b0;
  end

endmodule
